// File: rtl/set_assoc_cache_ctrl.sv
// Write-back, write-allocate set-associative cache controller with age-based replacement.
// One request in flight; misses write back a dirty victim, then fill the block beat by beat.
module set_assoc_cache_ctrl #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SETS        = 8,
    parameter int unsigned WAYS        = 4,
    parameter int unsigned BLOCK_WORDS = 16,
    parameter int unsigned STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [STAT_W-1:0] rd_hits,
    output logic [STAT_W-1:0] rd_misses,
    output logic [STAT_W-1:0] wr_hits,
    output logic [STAT_W-1:0] wr_misses
);
    localparam int unsigned OFF_W = $clog2(BLOCK_WORDS);
    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - SET_W;
    localparam int unsigned LINES = SETS * WAYS;
    localparam int unsigned WORDS = LINES * BLOCK_WORDS;
    localparam logic [OFF_W-1:0] BEAT_LAST = '1;
    localparam logic [WAY_W-1:0] AGE_MAX   = '1;

    typedef enum logic [2:0] {StIdle, StLookup, StWb, StFill, StResp} state_e;
    state_e state_q, state_d;

    logic              req_ready_q;
    logic              we_q;
    logic [TAG_W-1:0]  req_tag_q;
    logic [SET_W-1:0]  req_set_q;
    logic [OFF_W-1:0]  req_off_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hit_q;
    logic [WAY_W-1:0]  way_q;
    logic [OFF_W-1:0]  beat_q;

    logic              valid_q [LINES];
    logic              dirty_q [LINES];
    logic [TAG_W-1:0]  ltag_q  [LINES];
    logic [WAY_W-1:0]  age_q   [LINES];
    logic [DATA_W-1:0] data_q  [WORDS];

    logic              resp_valid_q, resp_hit_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [STAT_W-1:0] rd_hits_q, rd_misses_q, wr_hits_q, wr_misses_q;

    logic              hit, inv_found;
    logic [WAY_W-1:0]  hit_way, inv_way, old_way, victim;
    logic [WAY_W-1:0]  old_age;
    logic              accept;

    assign accept = (state_q == StIdle) && req_valid && req_ready_q;

    // Tag match plus victim choice: lowest invalid way, else oldest (lowest index on tie).
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        old_way   = '0;
        old_age   = age_q[{req_set_q, WAY_W'(0)}];
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[{req_set_q, WAY_W'(w)}] && ltag_q[{req_set_q, WAY_W'(w)}] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[{req_set_q, WAY_W'(w)}]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 1; w < int'(WAYS); w++) begin
            if (age_q[{req_set_q, WAY_W'(w)}] > old_age) begin
                old_age = age_q[{req_set_q, WAY_W'(w)}];
                old_way = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : old_way;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StLookup;
            end
            StLookup: begin
                if (hit) begin
                    state_d = StResp;
                end else if (valid_q[{req_set_q, victim}] && dirty_q[{req_set_q, victim}]) begin
                    state_d = StWb;
                end else begin
                    state_d = StFill;
                end
            end
            StWb: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {ltag_q[{req_set_q, way_q}], req_set_q, beat_q};
                mem_wdata = data_q[{way_q, req_set_q, beat_q}];
                if (mem_ready && beat_q == BEAT_LAST) state_d = StFill;
            end
            StFill: begin
                mem_valid = 1'b1;
                mem_addr  = {req_tag_q, req_set_q, beat_q};
                if (mem_ready && beat_q == BEAT_LAST) state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q  <= 1'b0;
            we_q         <= 1'b0;
            req_tag_q    <= '0;
            req_set_q    <= '0;
            req_off_q    <= '0;
            wdata_q      <= '0;
            hit_q        <= 1'b0;
            way_q        <= '0;
            beat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            rd_hits_q    <= '0;
            rd_misses_q  <= '0;
            wr_hits_q    <= '0;
            wr_misses_q  <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                ltag_q[i]  <= '0;
                age_q[i]   <= '0;
            end
        end else begin
            req_ready_q  <= (state_d == StIdle);
            resp_valid_q <= 1'b0;
            if (accept) begin
                we_q      <= req_we;
                req_tag_q <= req_addr[ADDR_W-1 -: TAG_W];
                req_set_q <= req_addr[OFF_W +: SET_W];
                req_off_q <= req_addr[OFF_W-1:0];
                wdata_q   <= req_wdata;
            end
            if (state_q == StLookup) begin
                hit_q  <= hit;
                way_q  <= hit ? hit_way : victim;
                beat_q <= '0;
            end
            if ((state_q == StWb || state_q == StFill) && mem_ready) begin
                beat_q <= beat_q + OFF_W'(1);
                if (state_q == StFill && beat_q == BEAT_LAST) begin
                    valid_q[{req_set_q, way_q}] <= 1'b1;
                    dirty_q[{req_set_q, way_q}] <= 1'b0;
                    ltag_q[{req_set_q, way_q}]  <= req_tag_q;
                end
            end
            if (state_q == StResp) begin
                resp_valid_q <= 1'b1;
                resp_hit_q   <= hit_q;
                resp_rdata_q <= we_q ? wdata_q : data_q[{way_q, req_set_q, req_off_q}];
                if (we_q) dirty_q[{req_set_q, way_q}] <= 1'b1;
                for (int w = 0; w < int'(WAYS); w++) begin
                    if (WAY_W'(w) == way_q) begin
                        age_q[{req_set_q, WAY_W'(w)}] <= '0;
                    end else if (valid_q[{req_set_q, WAY_W'(w)}] &&
                                 age_q[{req_set_q, WAY_W'(w)}] != AGE_MAX) begin
                        age_q[{req_set_q, WAY_W'(w)}] <= age_q[{req_set_q, WAY_W'(w)}] + WAY_W'(1);
                    end
                end
                if (we_q && hit_q) begin
                    if (wr_hits_q != '1) wr_hits_q <= wr_hits_q + STAT_W'(1);
                end else if (we_q) begin
                    if (wr_misses_q != '1) wr_misses_q <= wr_misses_q + STAT_W'(1);
                end else if (hit_q) begin
                    if (rd_hits_q != '1) rd_hits_q <= rd_hits_q + STAT_W'(1);
                end else begin
                    if (rd_misses_q != '1) rd_misses_q <= rd_misses_q + STAT_W'(1);
                end
            end
        end
    end

    // Data array is deliberately not reset; only valid lines are ever read.
    always_ff @(posedge clk) begin
        if (state_q == StFill && mem_ready) data_q[{way_q, req_set_q, beat_q}] <= mem_rdata;
        if (state_q == StResp && we_q) data_q[{way_q, req_set_q, req_off_q}] <= wdata_q;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign rd_hits    = rd_hits_q;
    assign rd_misses  = rd_misses_q;
    assign wr_hits    = wr_hits_q;
    assign wr_misses  = wr_misses_q;

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: backing memory model, response/beat scoreboard,
// plus a STAT_W=2 twin sharing all inputs to exercise counter saturation.
module tb_set_assoc_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_hit;
    logic [15:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] rd_hits, rd_misses, wr_hits, wr_misses;

    logic        d2_req_ready, d2_resp_valid, d2_resp_hit, d2_mem_valid, d2_mem_we;
    logic [15:0] d2_resp_rdata, d2_mem_wdata;
    logic [11:0] d2_mem_addr;
    logic [1:0]  s_rd_hits, s_rd_misses, s_wr_hits, s_wr_misses;

    always #5 clk = ~clk;

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rd_hits(rd_hits), .rd_misses(rd_misses), .wr_hits(wr_hits), .wr_misses(wr_misses)
    );

    set_assoc_cache_ctrl #(.STAT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d2_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(d2_resp_valid), .resp_rdata(d2_resp_rdata), .resp_hit(d2_resp_hit),
        .mem_valid(d2_mem_valid), .mem_ready(mem_ready), .mem_we(d2_mem_we),
        .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata), .mem_rdata(mem_rdata),
        .rd_hits(s_rd_hits), .rd_misses(s_rd_misses), .wr_hits(s_wr_hits), .wr_misses(s_wr_misses)
    );

    logic [15:0] tbmem  [4096];
    logic [15:0] shadow [4096];
    assign mem_rdata = tbmem[mem_addr];

    typedef struct {
        logic        hit;
        logic [15:0] data;
        string       name;
    } resp_t;

    resp_t       exp_resp_q[$];
    logic [12:0] exp_beats_q[$];
    logic [12:0] obs_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_beats = 0;
    int exp_rh = 0, exp_rm = 0, exp_wh = 0, exp_wm = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Beats are sampled mid-cycle; mem_ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (mem_valid && mem_ready) begin
            obs_q.push_back({mem_we, mem_addr});
            if (mem_we) tbmem[mem_addr] = mem_wdata;
            else rd_beats++;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_stats(input string name);
        chk({name, "_rd_hits"}, rd_hits, exp_rh);
        chk({name, "_rd_misses"}, rd_misses, exp_rm);
        chk({name, "_wr_hits"}, wr_hits, exp_wh);
        chk({name, "_wr_misses"}, wr_misses, exp_wm);
        chk({name, "_sat_rd_hits"}, s_rd_hits, sat3(exp_rh));
        chk({name, "_sat_rd_misses"}, s_rd_misses, sat3(exp_rm));
        chk({name, "_sat_wr_hits"}, s_wr_hits, sat3(exp_wh));
        chk({name, "_sat_wr_misses"}, s_wr_misses, sat3(exp_wm));
    endtask

    task automatic push_burst(input logic we, input logic [11:0] base);
        for (int i = 0; i < 16; i++) exp_beats_q.push_back({we, base + 12'(i)});
    endtask

    task automatic expect_resp(input logic we, input logic [11:0] a, input logic [15:0] wd,
                               input logic hit, input string name);
        resp_t e;
        e.hit  = hit;
        e.data = we ? wd : shadow[a];
        e.name = name;
        exp_resp_q.push_back(e);
        if (we) shadow[a] = wd;
        if (we && hit) exp_wh++;
        else if (we) exp_wm++;
        else if (hit) exp_rh++;
        else exp_rm++;
    endtask

    task automatic issue(input logic we, input logic [11:0] a, input logic [15:0] wd,
                         output int acc);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic finish_access(input int acc);
        int n;
        resp_t e;
        logic [12:0] eb, ob;
        n = 0;
        while (!resp_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("resp_seen", resp_valid, 1);
        e = exp_resp_q.pop_front();
        chk({e.name, "_hit"}, resp_hit, e.hit);
        chk({e.name, "_rdata"}, resp_rdata, e.data);
        if (e.hit) chk({e.name, "_latency"}, cyc - acc, 2);
        while (exp_beats_q.size() > 0) begin
            eb = exp_beats_q.pop_front();
            ob = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            chk({e.name, "_beat"}, ob, eb);
        end
        chk({e.name, "_extra_beats"}, obs_q.size(), 0);
        check_stats(e.name);
        @(negedge clk);
        chk({e.name, "_pulse_end"}, resp_valid, 0);
        chk({e.name, "_rdata_held"}, resp_rdata, e.data);
    endtask

    task automatic access(input logic we, input logic [11:0] a, input logic [15:0] wd,
                          input logic hit, input string name);
        int acc;
        expect_resp(we, a, wd, hit, name);
        issue(we, a, wd, acc);
        finish_access(acc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        for (int i = 0; i < 4096; i++) begin
            tbmem[i]  = 16'((i * 40503) ^ 23130);
            shadow[i] = tbmem[i];
        end
        tbmem[12'h022]  = 16'h000E;
        shadow[12'h022] = 16'h000E;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        mem_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_twin_outs", {d2_req_ready, d2_resp_valid, d2_resp_hit, d2_mem_valid, d2_mem_we}, 0);
        chk("rst_twin_data", {d2_resp_rdata, d2_mem_wdata}, 0);
        chk("rst_twin_addr", d2_mem_addr, 0);
        check_stats("rst");
        rst = 1'b0;
        chk("ready_at_release", req_ready, 0);
        @(posedge clk);
        #1 chk("ready_after_release", req_ready, 1);

        // Cold miss, then write hit and read hit on the same word.
        push_burst(1'b0, 12'h020);
        access(1'b0, 12'h022, 16'h0, 1'b0, "cold_read");
        access(1'b1, 12'h022, 16'h1234, 1'b1, "write_hit");
        access(1'b0, 12'h022, 16'h0, 1'b1, "read_hit");

        // Fill the rest of set 2, then force eviction of the dirty oldest way.
        push_burst(1'b0, 12'h0A0);
        access(1'b0, 12'h0A0, 16'h0, 1'b0, "fill_t1");
        push_burst(1'b0, 12'h120);
        access(1'b0, 12'h120, 16'h0, 1'b0, "fill_t2");
        push_burst(1'b0, 12'h1A0);
        access(1'b0, 12'h1A0, 16'h0, 1'b0, "fill_t3");
        push_burst(1'b1, 12'h020);
        push_burst(1'b0, 12'h220);
        access(1'b0, 12'h220, 16'h0, 1'b0, "evict_t4");
        chk("wb_word_022", tbmem[12'h022], 16'h1234);
        chk("wb_word_02f", tbmem[12'h02F], shadow[12'h02F]);
        access(1'b0, 12'h0A5, 16'h0, 1'b1, "survivor_hit");

        // Memory stall in the middle of a fill.
        expect_resp(1'b0, 12'h330, 16'h0, 1'b0, "stall_fill");
        push_burst(1'b0, 12'h330);
        rd_beats = 0;
        issue(1'b0, 12'h330, 16'h0, acc);
        n = 0;
        while (rd_beats < 8 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("stall_reach", rd_beats, 8);
        mem_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", mem_valid, 1);
            chk("stall_addr", mem_addr, 12'h338);
        end
        @(posedge clk);
        #2 mem_ready = 1'b1;
        finish_access(acc);

        // Write miss allocates; repeated read hits saturate the 2-bit twin.
        push_burst(1'b0, 12'h440);
        access(1'b1, 12'h444, 16'hBEEF, 1'b0, "write_miss");
        access(1'b0, 12'h444, 16'h0, 1'b1, "rd_hit_a");
        access(1'b0, 12'h444, 16'h0, 1'b1, "rd_hit_b");
        access(1'b0, 12'h444, 16'h0, 1'b1, "rd_hit_c");
        chk("sat_rd_hits_held", s_rd_hits, 2'd3);

        // Reset in the middle of a fill burst.
        rd_beats = 0;
        issue(1'b0, 12'h555, 16'h0, acc);
        n = 0;
        while (rd_beats < 7 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("mid_fill_reach", rd_beats, 7);
        rst = 1'b1;
        #1;
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        exp_rh = 0;
        exp_rm = 0;
        exp_wh = 0;
        exp_wm = 0;
        check_stats("midrst");
        @(negedge clk);
        @(negedge clk);
        obs_q.delete();
        exp_beats_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1 chk("midrst_ready_after", req_ready, 1);
        push_burst(1'b0, 12'h550);
        access(1'b0, 12'h555, 16'h0, 1'b0, "post_rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
